// File: rtl/axis_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_gen_pkg
// Shared definitions for the multi-channel AXI-Stream traffic generator:
//   - payload mode encodings (INC / LFSR / CONST, code 3 falls back to INC)
//   - Galois LFSR tap constant and single-step helper
//   - per-channel FSM state enum
// -----------------------------------------------------------------------------
package axis_gen_pkg;

    localparam logic [1:0]  MODE_INC   = 2'd0;
    localparam logic [1:0]  MODE_LFSR  = 2'd1;
    localparam logic [1:0]  MODE_CONST = 2'd2;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } ch_state_e;

    // One step of a right-shifting Galois LFSR: the bit shifted out selects
    // whether the tap pattern is folded back into the state.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/axis_gen_channel.sv
// -----------------------------------------------------------------------------
// axis_gen_channel
// One AXI-Stream master channel of the traffic generator: packet FSM,
// in-packet / packet / gap / beat counters, stop-pending flag and LFSR.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   launch              accepted start with this channel enabled
//   clear               accepted start (resets counters of every channel)
//   fin_release         every launched channel has reached FIN
//   stop                stop request (already masked against start)
//   mode, const_val,    latched run configuration; pkt_len is already
//   pkt_len, num_pkts,  forced to at least 1
//   gap
//   tready / tdata, tvalid, tlast   AXI-Stream master side
//   beat_cnt            handshakes since the last accepted start
//   fin                 channel sits in FIN
// -----------------------------------------------------------------------------
module axis_gen_channel
    import axis_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          LEN_W      = 8,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] SEED       = 32'hACE1_2024,
    parameter int          CH_IDX     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  launch,
    input  logic                  clear,
    input  logic                  fin_release,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_val,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [CNT_W-1:0]      num_pkts,
    input  logic [CNT_W-1:0]      gap,
    input  logic                  tready,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    output logic                  tlast,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  fin
);

    localparam logic [31:0] LFSR_SEED = SEED ^ 32'(CH_IDX + 1);

    ch_state_e         state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  pkt_q, pkt_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              stop_pend_q, stop_pend_d;

    logic                  hs;
    logic                  stop_now;
    logic [CNT_W-1:0]      pkt_next;
    logic [DATA_WIDTH-9:0] inc_idx;
    logic [DATA_WIDTH-1:0] payload;

    assign tvalid   = (state_q == ST_SEND);
    assign tlast    = tvalid && (idx_q == (pkt_len - LEN_W'(1)));
    assign hs       = tvalid & tready;
    assign stop_now = stop_pend_q | stop;
    assign pkt_next = pkt_q + CNT_W'(1);
    assign beat_cnt = beat_q;
    assign fin      = (state_q == ST_FIN);

    // Next-state logic. A stop never cuts a packet short: it is only acted
    // on at the tlast handshake or while idling in a gap. An accepted start
    // overrides everything and rearms the channel from a clean slate.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pkt_d       = pkt_q;
        gap_d       = gap_q;
        beat_d      = beat_q;
        lfsr_d      = lfsr_q;
        stop_pend_d = stop_pend_q | stop;

        case (state_q)
            ST_SEND: begin
                if (hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                    if (tlast) begin
                        idx_d = '0;
                        pkt_d = pkt_next;
                        if (((num_pkts != '0) && (pkt_next == num_pkts)) || stop_now) begin
                            state_d = ST_FIN;
                        end else if (gap != '0) begin
                            state_d = ST_GAP;
                            gap_d   = gap - CNT_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (stop_now) begin
                    state_d = ST_FIN;
                end else if (gap_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            ST_FIN: begin
                if (fin_release) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (clear) begin
            state_d     = launch ? ST_SEND : ST_IDLE;
            idx_d       = '0;
            pkt_d       = '0;
            gap_d       = '0;
            beat_d      = '0;
            lfsr_d      = LFSR_SEED;
            stop_pend_d = 1'b0;
        end
    end

    // Payload selection. Data is forced to zero whenever tvalid is low so the
    // bus reads all-zero out of reset and between packets.
    always_comb begin
        inc_idx              = '0;
        inc_idx[CNT_W-1:0]   = beat_q;
        case (mode)
            MODE_LFSR:  payload = {(DATA_WIDTH/32){lfsr_q}};
            MODE_CONST: payload = const_val;
            default:    payload = {8'(CH_IDX), inc_idx};
        endcase
        tdata = tvalid ? payload : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pkt_q       <= '0;
            gap_q       <= '0;
            beat_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pkt_q       <= pkt_d;
            gap_q       <= gap_d;
            beat_q      <= beat_d;
            lfsr_q      <= lfsr_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule

// File: rtl/axis_traffic_gen_mc.sv
// -----------------------------------------------------------------------------
// axis_traffic_gen_mc
// Multi-channel AXI-Stream traffic generator. Latches the run configuration
// on an accepted start, launches the enabled channels, joins their FIN states
// and produces busy / done.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, stop                run control pulses
//   ch_en, mode, const_val,    run configuration, sampled on accepted start
//   pkt_len, num_pkts, gap
//   axis_tdata/tvalid/tlast    NUM_CH master streams, channel c at slice c
//   axis_tready                per-channel ready
//   busy                       some launched channel has not finished
//   done                       one-cycle pulse when all launched channels end
//   beat_cnt                   per-channel handshake counters
// -----------------------------------------------------------------------------
module axis_traffic_gen_mc
    import axis_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          NUM_CH     = 4,
    parameter int          LEN_W      = 8,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [1:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        const_val,
    input  logic [LEN_W-1:0]             pkt_len,
    input  logic [CNT_W-1:0]             num_pkts,
    input  logic [CNT_W-1:0]             gap,
    output logic [NUM_CH*DATA_WIDTH-1:0] axis_tdata,
    output logic [NUM_CH-1:0]            axis_tvalid,
    output logic [NUM_CH-1:0]            axis_tlast,
    input  logic [NUM_CH-1:0]            axis_tready,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CH*CNT_W-1:0]      beat_cnt
);

    logic                  active_q, active_d;
    logic [NUM_CH-1:0]     launched_q, launched_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] const_q, const_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      gap_q, gap_d;

    logic [NUM_CH-1:0]     fin;
    logic                  all_fin;
    logic                  accept;
    logic                  stop_eff;

    // A run with no launched channels is trivially finished, which gives the
    // one-cycle done pulse without busy for an all-disabled start.
    assign all_fin  = &(fin | ~launched_q);
    assign done     = active_q & all_fin;
    assign busy     = active_q & ~all_fin;
    assign accept   = start & ~busy;
    assign stop_eff = stop & ~start;

    // Run bookkeeping: configuration is captured only on an accepted start,
    // and the run closes in the cycle where done is shown.
    always_comb begin
        active_d   = active_q;
        launched_d = launched_q;
        mode_d     = mode_q;
        const_d    = const_q;
        len_d      = len_q;
        num_d      = num_q;
        gap_d      = gap_q;
        if (accept) begin
            active_d   = 1'b1;
            launched_d = ch_en;
            mode_d     = mode;
            const_d    = const_val;
            len_d      = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
            num_d      = num_pkts;
            gap_d      = gap;
        end else if (done) begin
            active_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            launched_q <= '0;
            mode_q     <= MODE_INC;
            const_q    <= '0;
            len_q      <= LEN_W'(1);
            num_q      <= '0;
            gap_q      <= '0;
        end else begin
            active_q   <= active_d;
            launched_q <= launched_d;
            mode_q     <= mode_d;
            const_q    <= const_d;
            len_q      <= len_d;
            num_q      <= num_d;
            gap_q      <= gap_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        axis_gen_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEN_W      (LEN_W),
            .CNT_W      (CNT_W),
            .SEED       (SEED),
            .CH_IDX     (c)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .launch      (accept & ch_en[c]),
            .clear       (accept),
            .fin_release (done),
            .stop        (stop_eff),
            .mode        (mode_q),
            .const_val   (const_q),
            .pkt_len     (len_q),
            .num_pkts    (num_q),
            .gap         (gap_q),
            .tready      (axis_tready[c]),
            .tdata       (axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .tvalid      (axis_tvalid[c]),
            .tlast       (axis_tlast[c]),
            .beat_cnt    (beat_cnt[c*CNT_W +: CNT_W]),
            .fin         (fin[c])
        );
    end

endmodule

// File: doc/axis_traffic_gen_mc.md
# axis_traffic_gen_mc

Multi-channel, parametrised AXI-Stream traffic generator, the next generation of the single-channel `axis_traffic_gen` used to drive the mlp dispatcher input FIFOs. It supports:
- `NUM_CH` independent master streams.
- Selectable payload modes: incrementing, LFSR and constant.
- Packetisation with `tlast`, inter-packet gaps, packet-count limits and a graceful stop.
- Per-channel beat counters, so a bench or on-chip test harness can load every dispatcher concurrently with deterministic, checkable traffic.

## Interface
- `DATA_WIDTH`, 64: tdata width per channel; must be a multiple of 32, ≥ 32.
- `NUM_CH`, 4: number of channels, 1..16.
- `LEN_W`, 8: width of packet-length field.
- `CNT_W`, 16: width of packet-count, gap and beat-counter fields.
- `SEED`, 32'hACE1_2024: LFSR base seed.
- `clk  in  1`  clock, all logic on rising edge.
- `rst  in  1`  asynchronous, active-low reset.
- `start  in  1`  single-cycle pulse; latches config and launches all channels enabled in `ch_en`.
- `stop  in  1`  pulse; each active channel completes its current packet, then finishes.
- `ch_en  in  NUM_CH`  channel enable mask, latched on `start`.
- `mode  in  2`  0 = INC, 1 = LFSR, 2 = CONST, 3 = reserved (treated as INC).
- `const_val  in  DATA_WIDTH`  payload for CONST mode.
- `pkt_len  in  LEN_W`  beats per packet; 0 is treated as 1.
- `num_pkts  in  CNT_W`  packets per channel; 0 means unlimited until `stop`.
- `gap  in  CNT_W`  idle cycles between the `tlast` handshake and the next packet's first beat.
- `axis_tdata  out  NUM_CH*DATA_WIDTH`  channel c occupies bits `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `axis_tvalid  out  NUM_CH`.
- `axis_tlast  out  NUM_CH`.
- `axis_tready  in  NUM_CH`.
- `busy  out  1`  high while any launched channel is not finished.
- `done  out  1`  one-cycle pulse when the last active channel finishes.
- `beat_cnt  out  NUM_CH*CNT_W`  per-channel handshake count since `start`; wraps modulo 2^CNT_W.

## Operation
- **Per-channel FSM states:** IDLE, SEND, GAP, FIN.
- **IDLE → SEND:** on `start` with `ch_en[c]` = 1.
  - Disabled channels stay in IDLE.
  - `start` while `busy` is ignored entirely.
- **SEND:**
  - `tvalid` = 1.
  - A beat completes on `tvalid & tready`.
  - `tlast` = 1 on the beat where the in-packet index = effective `pkt_len`-1.
- **After the `tlast` handshake:**
  - → FIN if `num_pkts` ≠ 0 and the packet count is reached, or if a stop is pending.
  - Else → GAP if `gap` ≠ 0.
  - Else stay in SEND (back-to-back packets).
- **GAP:** counts `gap` cycles with `tvalid` = 0, then → SEND.
  - A stop pending in GAP → FIN immediately.
- **FIN:** holds until all launched channels are in FIN. Then `done` pulses, and all channels → IDLE in the same cycle.
- **Stop:** `stop` sets a per-channel pending flag; the flag clears on `start`. A `stop` arriving in the same cycle as `start` is ignored.
- **Payload by mode:**
  - INC: tdata = {`c`[7:0], beat index zero-extended to DATA_WIDTH-8}. The beat index counts across packets from 0.
  - LFSR: Galois 32-bit, taps 32'h8020_0003. Per-channel seed = `SEED ^ (c+1)`. tdata = the 32-bit state replicated DATA_WIDTH/32 times. The state advances only on handshake.
  - CONST: tdata = `const_val`.
- **Mid-operation reset:** all channels return to IDLE, outputs go to their reset values, and there is no partial-packet recovery.

## Timing
- **Reset values:** `axis_tvalid`, `axis_tlast`, `axis_tdata`, `busy`, `done` and `beat_cnt` are all 0.
- **Start latency:** `start` sampled at edge T → `busy` = 1 and `tvalid` = 1 after edge T (visible during cycle T+1), with the first beat's data valid.
- **AXIS rule:** once `tvalid` is asserted, `tdata` and `tlast` are held stable until the handshake, and `tvalid` never drops without a handshake. `stop` never truncates a beat.
- **Throughput:** 1 beat/cycle per channel under continuous `tready`. Channels are fully independent; backpressure on one channel does not affect another.
- **Gap:** with `gap` = G, exactly G cycles with `tvalid` = 0 between the `tlast` handshake cycle and the next valid beat.
- **Done:** `done` is asserted in the cycle after the final channel's `tlast` handshake. `busy` falls in that same cycle.
- **All channels disabled:** `start` with `ch_en` = 0 produces a `done` pulse 1 cycle later, and `busy` never rises.

## Structure
- **Package `axis_gen_pkg`:** mode encodings (`MODE_INC`, `MODE_LFSR`, `MODE_CONST`), the LFSR tap constant, and the FSM state enum.
- **Sub-module `axis_gen_channel`:** per-channel FSM, counters and LFSR.
  - The top level instantiates it NUM_CH times in a generate loop.
  - The top level also owns config latching, the FIN join, and `busy`/`done`.

## Test plan
- **INC:** NUM_CH=4, `pkt_len`=4, `num_pkts`=2, `gap`=0, `tready`=1 → each channel emits 8 beats back-to-back, `tlast` on beats 3 and 7. Channel 2 beat 5 tdata = 64'h0200_0000_0000_0005. `done` pulses at cycle T+9.
- **Backpressure:** random `tready` on channel 1 only → channel 1 tdata/tlast stable while stalled, channels 0/2/3 finish in 8 cycles, `beat_cnt` = 8 on all channels.
- **Gap:** `gap`=3, `pkt_len`=2, `num_pkts`=3 → exactly 3 `tvalid`-low cycles after each `tlast` handshake. Total 6 beats, finished by cycle T+13.
- **LFSR:** first two beats of channel 0 = replicated `SEED^1`, then its Galois successor. The state is unchanged across stalled cycles.
- **Stop with `num_pkts`=0, `pkt_len`=5:** `stop` at beat 2 → the packet completes through `tlast`, then `done` pulses. A `start` issued while `busy` is ignored.
- **Async reset:** reset mid-packet → all outputs return to 0 immediately. Edge cases: a later `start` restarts the beat index at 0; `pkt_len`=0 gives single-beat packets with `tlast`=1 on every beat.
